// File: rtl/dw_pkg.sv
// Shared types and size helpers for the depthwise weight stream buffer.
package dw_pkg;

    localparam int DW_DATA_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } dw_state_t;

    function automatic int dw_kk(input int kernel);
        return kernel * kernel;
    endfunction

    function automatic int dw_depth(input int channels, input int kernel);
        return channels * dw_kk(kernel);
    endfunction

endpackage

// File: rtl/dw_wbuf_ram.sv
// Single-port inferred block RAM, 1-cycle registered read, no reset on contents.
// Read data holds between reads; writes return nothing on dout.
module dw_wbuf_ram #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 2304,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dw_weight_stream_buf.sv
// Depthwise weight buffer: burst load, then per-channel tap streaming; first tap 2 cycles after accept,
// 1 tap/cycle through a 2-entry skid buffer under w_ready backpressure. Optional DW_WBUF_PARITY_EN.
module dw_weight_stream_buf
    import dw_pkg::*;
#(
    parameter int DATA_W   = DW_DATA_W,
    parameter int KERNEL   = 3,
    parameter int CHANNELS = 256,
    parameter int ADDR_W   = $clog2(CHANNELS * KERNEL * KERNEL),
    // One headroom bit so requests beyond CHANNELS can be expressed and flagged.
    parameter int CH_W     = $clog2(CHANNELS) + 1,
    parameter int TAP_W    = $clog2(KERNEL * KERNEL)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DW_WBUF_PARITY_EN
    output logic              par_err,
`endif
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              rd_valid,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              rd_ready,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [TAP_W-1:0]  w_tap,
    output logic              w_last,
    output logic              busy,
    output logic              range_err
);

    localparam int KK    = dw_kk(KERNEL);
    localparam int DEPTH = dw_depth(CHANNELS, KERNEL);
`ifdef DW_WBUF_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam logic [CH_W-1:0]   CH_LIM    = CH_W'(CHANNELS);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(KK - 1);

    dw_state_t         state, state_nxt;
    logic [CH_W-1:0]   ch_q, ch_sel;
    logic [TAP_W-1:0]  tap_q, tap_sel;
    logic [ADDR_W:0]   wptr;
    logic              issue, accept_rd, ld_acc, oor_sel, wr_ok, pop, room;
    logic [1:0]        occ;

    logic              rvld, rlast, rzero;
    logic [TAP_W-1:0]  rtap;

    logic [DATA_W-1:0] sk_data [2];
    logic [TAP_W-1:0]  sk_tap  [2];
    logic              sk_last [2];
    logic              sk_wp, sk_rp;
    logic [1:0]        sk_cnt;

    logic              ram_en, ram_we, par_bad;
    logic [ADDR_W-1:0] ram_addr, rd_addr;
    logic [RAM_W-1:0]  ram_din, ram_dout;
    logic [DATA_W-1:0] rd_word;

    assign w_valid = (sk_cnt != 2'd0);
    assign pop     = w_valid & w_ready;
    // Occupancy one cycle ahead, counting the read already in flight; issue only if a slot is guaranteed.
    assign occ     = sk_cnt + {1'b0, rvld} - {1'b0, pop};
    assign room    = (occ <= 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_ready  = 1'b0;
        ld_ready  = 1'b0;
        issue     = 1'b0;
        accept_rd = 1'b0;
        ld_acc    = 1'b0;
        ch_sel    = ch_q;
        tap_sel   = tap_q;
        case (state)
            ST_IDLE: begin
                rd_ready = ~ld_start;
                if (ld_start) begin
                    state_nxt = ST_LOAD;
                end else if (rd_valid) begin
                    // Tap 0 is read in the accept cycle to reach the output two cycles later.
                    accept_rd = 1'b1;
                    issue     = 1'b1;
                    ch_sel    = rd_ch;
                    tap_sel   = '0;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ld_acc = 1'b1;
                    if (ld_last) state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (room) begin
                    issue = 1'b1;
                    if (tap_q == TAP_LAST) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && w_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign oor_sel  = (ch_sel >= CH_LIM);
    assign wr_ok    = (wptr < DEPTH_LIM);
    assign rd_addr  = ADDR_W'(ch_sel) * ADDR_W'(KK) + ADDR_W'(tap_sel);
    assign ram_we   = ld_acc;
    assign ram_en   = (ld_acc & wr_ok) | (issue & ~oor_sel);
    assign ram_addr = ld_acc ? wptr[ADDR_W-1:0] : rd_addr;

`ifdef DW_WBUF_PARITY_EN
    assign ram_din = {^ld_data, ld_data};
    assign par_bad = rvld & ~rzero & (^ram_dout);
`else
    assign ram_din = ld_data;
    assign par_bad = 1'b0;
`endif
    assign rd_word = (rzero | par_bad) ? '0 : ram_dout[DATA_W-1:0];

    dw_wbuf_ram #(
        .WIDTH  (RAM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q      <= '0;
            tap_q     <= '0;
            wptr      <= '0;
            rvld      <= 1'b0;
            rtap      <= '0;
            rlast     <= 1'b0;
            rzero     <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (accept_rd) ch_q <= rd_ch;
            if (issue) tap_q <= tap_sel + 1'b1;
            // Write pointer saturates rather than wrapping back into valid space.
            if (state == ST_IDLE && ld_start) begin
                wptr <= {1'b0, ld_base};
            end else if (ld_acc && wptr != '1) begin
                wptr <= wptr + 1'b1;
            end
            rvld  <= issue;
            rtap  <= tap_sel;
            rlast <= (tap_sel == TAP_LAST);
            rzero <= oor_sel;
            if ((accept_rd & oor_sel) | (ld_acc & ~wr_ok)) range_err <= 1'b1;
        end
    end

`ifdef DW_WBUF_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err <= 1'b0;
        end else if (par_bad) begin
            par_err <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                sk_data[i] <= '0;
                sk_tap[i]  <= '0;
                sk_last[i] <= 1'b0;
            end
            sk_wp  <= 1'b0;
            sk_rp  <= 1'b0;
            sk_cnt <= 2'd0;
        end else begin
            if (rvld) begin
                sk_data[sk_wp] <= rd_word;
                sk_tap[sk_wp]  <= rtap;
                sk_last[sk_wp] <= rlast;
                sk_wp          <= ~sk_wp;
            end
            if (pop) sk_rp <= ~sk_rp;
            sk_cnt <= occ;
        end
    end

    assign w_data = sk_data[sk_rp];
    assign w_tap  = sk_tap[sk_rp];
    assign w_last = w_valid & sk_last[sk_rp];
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_dw_weight_stream_buf.sv
// Bench for dw_weight_stream_buf: request table plus hand-written corner sequences, scoreboarded taps.
`timescale 1ns/1ps
module tb_dw_weight_stream_buf;

    localparam int DATA_W = 14;
    localparam int KK     = 9;
    localparam int CH_W   = 9;
    localparam int ADDR_W = 12;
    localparam int TAP_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAP_W-1:0]  tap;
        logic              last;
    } tap_exp_t;

    typedef struct {
        int ch;
        int base;
        bit zero;
        bit exp_err;
    } req_vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ld_start = 1'b0;
    logic [ADDR_W-1:0] ld_base = '0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              ld_ready;
    logic              rd_valid = 1'b0;
    logic [CH_W-1:0]   rd_ch = '0;
    logic              rd_ready;
    logic              w_valid;
    logic              w_ready = 1'b1;
    logic [DATA_W-1:0] w_data;
    logic [TAP_W-1:0]  w_tap;
    logic              w_last;
    logic              busy;
    logic              range_err;
`ifdef DW_WBUF_PARITY_EN
    logic              par_err;
`endif

    dw_weight_stream_buf dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DW_WBUF_PARITY_EN
        .par_err   (par_err),
`endif
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .rd_valid  (rd_valid),
        .rd_ch     (rd_ch),
        .rd_ready  (rd_ready),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_tap     (w_tap),
        .w_last    (w_last),
        .busy      (busy),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    tap_exp_t sb[$];
    int       n_tests = 0;
    int       n_fail  = 0;
    bit       rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1 w_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: holds stalled outputs stable and pops the scoreboard on each transfer.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [TAP_W-1:0]  prev_tap;
    logic              prev_last;
    tap_exp_t          mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_stable", {12'd0, w_valid, w_data, w_tap, w_last},
                      {12'd0, 1'b1, prev_data, prev_tap, prev_last});
            end
            if (w_valid && w_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tap: got tap %0d data %0d, expected no transfer", w_tap, w_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("tap_data", 32'(w_data), 32'(mon_e.data));
                    check("tap_index", 32'(w_tap), 32'(mon_e.tap));
                    check("tap_last", 32'(w_last), 32'(mon_e.last));
                end
            end
            prev_stall = w_valid && !w_ready;
            prev_data  = w_data;
            prev_tap   = w_tap;
            prev_last  = w_last;
        end
    end

    task automatic push_taps(input int base, input bit zero);
        tap_exp_t e;
        for (int t = 0; t < KK; t++) begin
            e.data = zero ? '0 : DATA_W'((base + t) % 8192);
            e.tap  = TAP_W'(t);
            e.last = (t == KK - 1);
            sb.push_back(e);
        end
    endtask

    task automatic load_body(input int base, input int n, input bit stall);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < 4 * n + 20) begin
            cyc++;
            if (stall && (cyc % 3 == 0)) begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
            end else begin
                ld_valid = 1'b1;
                ld_data  = DATA_W'((base + i) % 8192);
                ld_last  = (i == n - 1);
            end
            @(negedge clk);
            acc = ld_valid && ld_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("load_words", i, n);
    endtask

    task automatic do_load(input int base, input int n, input bit stall);
        @(posedge clk);
        #1 ld_start = 1'b1;
        ld_base = ADDR_W'(base);
        @(posedge clk);
        #1 ld_start = 1'b0;
        load_body(base, n, stall);
    endtask

    task automatic do_req(input int ch);
        bit acc = 1'b0;
        @(posedge clk);
        #1 rd_valid = 1'b1;
        rd_ch = CH_W'(ch);
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (rd_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        rd_valid = 1'b0;
        check("req_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        check("stream_done", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_vec_t vec[5];
        int first, lastk, nval;
        bit rdy_low, found;

        vec[0] = '{0,   0,    1'b0, 1'b0};
        vec[1] = '{17,  153,  1'b0, 1'b0};
        vec[2] = '{255, 2295, 1'b0, 1'b0};
        vec[3] = '{5,   45,   1'b0, 1'b0};
        vec[4] = '{300, 0,    1'b1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_ready", rd_ready, 1);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_range_err", range_err, 0);
        check("rst_w_data", 32'(w_data), 0);
        check("rst_w_tap", 32'(w_tap), 0);
        check("rst_w_last", w_last, 0);
        #2 rst = 1'b1;

        do_load(0, 2304, 1'b1);
        check("load_range_err", range_err, 0);

        foreach (vec[i]) begin
            push_taps(vec[i].base, vec[i].zero);
            do_req(vec[i].ch);
            wait_idle();
            check("vec_range_err", range_err, 32'(vec[i].exp_err));
        end

        // Latency, throughput and rd_ready gating for a single stream.
        push_taps(45, 1'b0);
        do_req(5);
        first = -1; lastk = -1; nval = 0; rdy_low = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (w_valid) begin
                nval++;
                lastk = k;
                if (first < 0) first = k;
            end
            if (k <= 10 && rd_ready) rdy_low = 1'b0;
            if (k == 11) check("rd_ready_back", rd_ready, 1);
        end
        check("first_valid_delay", first, 2);
        check("last_valid_cycle", lastk, 10);
        check("valid_count", nval, 9);
        check("rd_ready_low_while_busy", rdy_low, 1);

        rand_rdy = 1'b1;
        push_taps(45, 1'b0);
        do_req(5);
        wait_idle();
        rand_rdy = 1'b0;

        do_load(2303, 2, 1'b0);
        check("oor_load_range_err", range_err, 1);

        // Load and request arrive together: load wins, request is served afterwards.
        @(posedge clk);
        #1 ld_start = 1'b1;
        ld_base  = ADDR_W'(45);
        rd_valid = 1'b1;
        rd_ch    = CH_W'(17);
        push_taps(153, 1'b0);
        @(negedge clk);
        check("collide_rd_ready", rd_ready, 0);
        @(posedge clk);
        #1 ld_start = 1'b0;
        @(negedge clk);
        check("collide_in_load_ld_ready", ld_ready, 1);
        check("collide_in_load_rd_ready", rd_ready, 0);
        @(posedge clk);
        #1;
        load_body(45, 3, 1'b0);
        @(negedge clk);
        check("req_after_load", rd_ready, 1);
        @(posedge clk);
        #1 rd_valid = 1'b0;
        wait_idle();

        // Reset during tap 4 of a stream.
        push_taps(45, 1'b0);
        do_req(5);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (w_valid && w_tap == 4'd4) found = 1'b1;
        end
        check("saw_tap4", found, 1);
        #2 rst = 1'b0;
        #1;
        check("reset_w_valid", w_valid, 0);
        check("reset_busy", busy, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_range_err", range_err, 0);
        #2 rst = 1'b1;
        push_taps(45, 1'b0);
        do_req(5);
        wait_idle();

`ifdef DW_WBUF_PARITY_EN
        check("par_err_clean", par_err, 0);
        dut.u_ram.mem[45][0] = ~dut.u_ram.mem[45][0];
        push_taps(45, 1'b0);
        sb[0].data = '0;
        do_req(5);
        wait_idle();
        check("par_err_set", par_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
